cory_pack: RTL and testbench

CORY_PACK -- requirements
Module: cory_pack

---
 rtl/cory_pack_if.sv | 30 +++
 rtl/cory_pack.sv | 96 +++++++++
 tb/tb_cory_pack.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cory_pack_if.sv
// Handshake bundle for cory_pack: packed-unit input stream and output stream.
// Packet-end signals exist only when CORY_PACK_LAST_EN is defined.
interface cory_pack_if #(
  parameter int N = 8,
  parameter int A = 3 * N,
  parameter int Z = 4 * N
);
  logic         i_a_v;
  logic [A-1:0] i_a_d;
  logic         o_a_r;
  logic         o_z_v;
  logic [Z-1:0] o_z_d;
  logic         i_z_r;
`ifdef CORY_PACK_LAST_EN
  localparam int NW = $clog2(Z / N) + 1;
  logic          i_a_l;
  logic [NW-1:0] o_z_n;
  logic          o_z_l;

  modport master (output i_a_v, i_a_d, i_a_l, i_z_r,
                  input  o_a_r, o_z_v, o_z_d, o_z_n, o_z_l);
  modport slave  (input  i_a_v, i_a_d, i_a_l, i_z_r,
                  output o_a_r, o_z_v, o_z_d, o_z_n, o_z_l);
`else
  modport master (output i_a_v, i_a_d, i_z_r,
                  input  o_a_r, o_z_v, o_z_d);
  modport slave  (input  i_a_v, i_a_d, i_z_r,
                  output o_a_r, o_z_v, o_z_d);
`endif
endinterface

// File: rtl/cory_pack.sv
// Width converter: packs NA-unit input words into NZ-unit output words via a Q-unit circular queue.
// Optional packet-end support (early flush on a last mark) is enabled with CORY_PACK_LAST_EN.
module cory_pack #(
  parameter int N = 8,
  parameter int A = 3 * N,
  parameter int Z = 4 * N,
  parameter int Q = A / N + Z / N
) (
  input  logic      clk,
  input  logic      reset,
  cory_pack_if.slave bus
);
  localparam int NA = A / N;
  localparam int NZ = Z / N;
  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = $clog2(Q + 1);
  localparam int NW = $clog2(NZ) + 1;

  logic [N-1:0]  q_q [Q];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_out;
  logic [Z-1:0]  z_data;
  logic          a_rdy, z_vld, push, pop;
`ifdef CORY_PACK_LAST_EN
  logic          q_last_q [Q];
  logic          z_last;
`endif

  // Sums never exceed 2*Q-1, so a single conditional subtract wraps any Q.
  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= Q) ? PW'(v - Q) : PW'(v);
  endfunction

  always_comb begin
    a_rdy = (int'(cnt_q) + NA <= Q);
    n_out = NW'(NZ);
    z_vld = (int'(cnt_q) >= NZ);
`ifdef CORY_PACK_LAST_EN
    z_last = 1'b0;
    // Scan downwards so the oldest marked unit in the window wins.
    for (int k = NZ - 1; k >= 0; k--) begin
      if (k < int'(cnt_q) && q_last_q[wrap(int'(rptr_q) + k)]) begin
        n_out  = NW'(k + 1);
        z_last = 1'b1;
      end
    end
    if (z_last) z_vld = 1'b1;
`endif
    z_data = '0;
    for (int k = 0; k < NZ; k++) begin
      z_data[k*N +: N] = (k < int'(n_out)) ? q_q[wrap(int'(rptr_q) + k)] : '0;
    end
    push   = bus.i_a_v && a_rdy;
    pop    = z_vld && bus.i_z_r;
    wptr_d = push ? wrap(int'(wptr_q) + NA) : wptr_q;
    rptr_d = pop ? wrap(int'(rptr_q) + int'(n_out)) : rptr_q;
    cnt_d  = CW'(int'(cnt_q) + (push ? NA : 0) - (pop ? int'(n_out) : 0));
  end

  // Queue/pointer register stage: output is a direct view of this state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      for (int k = 0; k < Q; k++) begin
        q_q[k] <= '0;
`ifdef CORY_PACK_LAST_EN
        q_last_q[k] <= 1'b0;
`endif
      end
    end else begin
      cnt_q  <= cnt_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      if (push) begin
        for (int k = 0; k < NA; k++) begin
          q_q[wrap(int'(wptr_q) + k)] <= bus.i_a_d[k*N +: N];
`ifdef CORY_PACK_LAST_EN
          q_last_q[wrap(int'(wptr_q) + k)] <= (k == NA - 1) && bus.i_a_l;
`endif
        end
      end
    end
  end

  assign bus.o_a_r = a_rdy;
  assign bus.o_z_v = z_vld;
  assign bus.o_z_d = z_data;
`ifdef CORY_PACK_LAST_EN
  assign bus.o_z_n = z_vld ? n_out : '0;
  assign bus.o_z_l = z_last;
`endif
endmodule

// File: tb/tb_cory_pack.sv
// Bench for cory_pack (N=8, A=24, Z=32, Q=7) using a byte-queue reference model.
// Define CORY_PACK_LAST_EN to also exercise packet-end handling.
module tb_cory_pack;
  localparam int N  = 8;
  localparam int A  = 24;
  localparam int Z  = 32;
  localparam int Q  = 7;
  localparam int NA = 3;
  localparam int NZ = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Reference model: queued bytes in arrival order plus their last marks.
  logic [7:0] mq[$];
  bit         ml[$];

  cory_pack_if #(.N(N), .A(A), .Z(Z)) bus ();
  cory_pack #(.N(N), .A(A), .Z(Z)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic int m_last_pos();
    int w = (mq.size() < NZ) ? mq.size() : NZ;
    for (int k = 0; k < w; k++) if (ml[k]) return k + 1;
    return 0;
  endfunction

  function automatic bit m_vld();
    return (m_last_pos() != 0) || (mq.size() >= NZ);
  endfunction

  function automatic int m_nout();
    return (m_last_pos() != 0) ? m_last_pos() : NZ;
  endfunction

  function automatic bit m_rdy();
    return (mq.size() + NA) <= Q;
  endfunction

  function automatic logic [Z-1:0] m_word();
    logic [Z-1:0] w = '0;
    for (int k = 0; k < m_nout(); k++) if (k < mq.size()) w[k*8 +: 8] = mq[k];
    return w;
  endfunction

  // Drive one cycle from a negedge, advance the model, return at the next negedge.
  task automatic drive_cycle(input bit v, input logic [A-1:0] d, input bit l, input bit zr,
                             output bit pushed);
    bit pop;
    int n;
    bus.i_a_v = v;
    bus.i_a_d = d;
    bus.i_z_r = zr;
`ifdef CORY_PACK_LAST_EN
    bus.i_a_l = l;
`endif
    pushed = v && m_rdy();
    pop    = m_vld() && zr;
    n      = m_nout();
    @(posedge clk);
    if (pop) for (int k = 0; k < n; k++) begin
      void'(mq.pop_front());
      void'(ml.pop_front());
    end
    if (pushed) for (int k = 0; k < NA; k++) begin
      mq.push_back(d[k*8 +: 8]);
      ml.push_back(l && (k == NA - 1));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.i_a_v = 1'b0;
    bus.i_z_r = 1'b0;
`ifdef CORY_PACK_LAST_EN
    bus.i_a_l = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    ml.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_z_v !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", bus.o_z_v); end
    checks++; if (bus.o_z_d !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.o_z_d); end
    checks++; if (bus.o_a_r !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%b exp=1", bus.o_a_r); end
`ifdef CORY_PACK_LAST_EN
    checks++; if (bus.o_z_n !== 3'd0) begin errors++; $display("FAIL rst_n got=%0d exp=0", bus.o_z_n); end
    checks++; if (bus.o_z_l !== 1'b0) begin errors++; $display("FAIL rst_l got=%b exp=0", bus.o_z_l); end
`endif
  endtask

  task automatic test_stream();
    logic [A-1:0] win [4];
    logic [Z-1:0] wout [3];
    logic [A-1:0] d;
    int wi = 0;
    int oi = 0;
    bit p;
    win  = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    wout = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bus.o_z_v === 1'b1) begin
        checks++;
        if (oi >= 3) begin
          errors++; $display("FAIL stream_extra got=%h exp=no_output", bus.o_z_d);
        end else if (bus.o_z_d !== wout[oi]) begin
          errors++; $display("FAIL stream_word%0d got=%h exp=%h", oi, bus.o_z_d, wout[oi]);
        end
        oi++;
      end
      d = (wi < 4) ? win[wi & 3] : '0;
      drive_cycle(wi < 4, d, 1'b0, 1'b1, p);
      if (p) wi++;
    end
    checks++; if (oi != 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", oi); end
  endtask

  task automatic test_backpressure();
    bit p;
    do_reset();
    drive_cycle(1'b1, 24'h030201, 1'b0, 1'b0, p);
    drive_cycle(1'b1, 24'h060504, 1'b0, 1'b0, p);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.o_a_r !== 1'b0) begin errors++; $display("FAIL bp_rdy%0d got=%b exp=0", i, bus.o_a_r); end
      checks++; if (bus.o_z_v !== 1'b1) begin errors++; $display("FAIL bp_vld%0d got=%b exp=1", i, bus.o_z_v); end
      checks++; if (bus.o_z_d !== 32'h04030201) begin errors++; $display("FAIL bp_data%0d got=%h exp=04030201", i, bus.o_z_d); end
      drive_cycle(1'b1, 24'h090807, 1'b0, 1'b0, p);
    end
    bus.i_z_r = 1'b1;
    #1;
    checks++; if (bus.o_a_r !== 1'b0) begin errors++; $display("FAIL bp_rdy_zr got=%b exp=0", bus.o_a_r); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1, p);
    checks++; if (bus.o_a_r !== 1'b1) begin errors++; $display("FAIL bp_rdy_after got=%b exp=1", bus.o_a_r); end
    checks++; if (bus.o_z_v !== 1'b0) begin errors++; $display("FAIL bp_vld_after got=%b exp=0", bus.o_z_v); end
  endtask

  task automatic test_simultaneous();
    bit p;
    do_reset();
    drive_cycle(1'b1, 24'h030201, 1'b0, 1'b0, p);
    drive_cycle(1'b1, 24'h060504, 1'b0, 1'b0, p);
    drive_cycle(1'b0, '0,         1'b0, 1'b1, p);
    drive_cycle(1'b1, 24'h090807, 1'b0, 1'b0, p);
    drive_cycle(1'b0, '0,         1'b0, 1'b1, p);
    drive_cycle(1'b1, 24'h0C0B0A, 1'b0, 1'b0, p);
    checks++; if (bus.o_a_r !== 1'b1) begin errors++; $display("FAIL sim_rdy4 got=%b exp=1", bus.o_a_r); end
    checks++; if (bus.o_z_d !== 32'h0C0B0A09) begin errors++; $display("FAIL sim_data4 got=%h exp=0c0b0a09", bus.o_z_d); end
    drive_cycle(1'b1, 24'h0F0E0D, 1'b0, 1'b1, p);
    checks++; if (bus.o_z_v !== 1'b0) begin errors++; $display("FAIL sim_vld3 got=%b exp=0", bus.o_z_v); end
    checks++; if (bus.o_a_r !== 1'b1) begin errors++; $display("FAIL sim_rdy3 got=%b exp=1", bus.o_a_r); end
    drive_cycle(1'b1, 24'h121110, 1'b0, 1'b0, p);
    checks++; if (bus.o_z_d !== 32'h100F0E0D) begin errors++; $display("FAIL sim_data6 got=%h exp=100f0e0d", bus.o_z_d); end
    checks++; if (bus.o_a_r !== 1'b0) begin errors++; $display("FAIL sim_rdy6 got=%b exp=0", bus.o_a_r); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    bit p, v, zr;
    logic [A-1:0] d;
    do_reset();
    for (int cyc = 0; cyc < 2000 && !(sent == 40 && mq.size() == 0); cyc++) begin
      checks++; if (bus.o_a_r !== m_rdy()) begin errors++; $display("FAIL wrap_rdy c%0d got=%b exp=%b", cyc, bus.o_a_r, m_rdy()); end
      checks++; if (bus.o_z_v !== m_vld()) begin errors++; $display("FAIL wrap_vld c%0d got=%b exp=%b", cyc, bus.o_z_v, m_vld()); end
      zr = (sent == 40) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_vld() && zr) begin
        checks++; if (bus.o_z_d !== m_word()) begin errors++; $display("FAIL wrap_data c%0d got=%h exp=%h", cyc, bus.o_z_d, m_word()); end
      end
      v = (sent < 40) && ($urandom_range(0, 3) != 0);
      d = A'($urandom);
      drive_cycle(v, d, 1'b0, zr, p);
      if (p) sent++;
    end
    checks++; if (sent != 40 || mq.size() != 0) begin errors++; $display("FAIL wrap_timeout sent=%0d left=%0d exp=40/0", sent, mq.size()); end
  endtask

  task automatic test_reset_midstream();
    bit p;
    do_reset();
    drive_cycle(1'b1, 24'h030201, 1'b0, 1'b0, p);
    drive_cycle(1'b1, 24'h060504, 1'b0, 1'b0, p);
    drive_cycle(1'b0, '0,         1'b0, 1'b1, p);
    drive_cycle(1'b1, 24'h090807, 1'b0, 1'b0, p);
    checks++; if (bus.o_z_v !== 1'b1) begin errors++; $display("FAIL mrst_pre_vld got=%b exp=1", bus.o_z_v); end
    reset     = 1'b1;
    bus.i_a_v = 1'b1;
    bus.i_a_d = 24'h5A5A5A;
    bus.i_z_r = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.i_a_v = 1'b0;
    mq.delete();
    ml.delete();
    checks++; if (bus.o_z_v !== 1'b0) begin errors++; $display("FAIL mrst_vld got=%b exp=0", bus.o_z_v); end
    checks++; if (bus.o_a_r !== 1'b1) begin errors++; $display("FAIL mrst_rdy got=%b exp=1", bus.o_a_r); end
    checks++; if (bus.o_z_d !== 32'h0) begin errors++; $display("FAIL mrst_data got=%h exp=0", bus.o_z_d); end
    drive_cycle(1'b1, 24'hA3A2A1, 1'b0, 1'b0, p);
    drive_cycle(1'b1, 24'hA6A5A4, 1'b0, 1'b0, p);
    checks++; if (bus.o_z_v !== 1'b1) begin errors++; $display("FAIL mrst_new_vld got=%b exp=1", bus.o_z_v); end
    checks++; if (bus.o_z_d !== 32'hA4A3A2A1) begin errors++; $display("FAIL mrst_new_data got=%h exp=a4a3a2a1", bus.o_z_d); end
  endtask

`ifdef CORY_PACK_LAST_EN
  task automatic test_last();
    bit p;
    do_reset();
    drive_cycle(1'b1, 24'h030201, 1'b1, 1'b0, p);
    checks++; if (bus.o_z_v !== 1'b1) begin errors++; $display("FAIL last_vld got=%b exp=1", bus.o_z_v); end
    checks++; if (bus.o_z_d !== 32'h00030201) begin errors++; $display("FAIL last_data got=%h exp=00030201", bus.o_z_d); end
    checks++; if (bus.o_z_n !== 3'd3) begin errors++; $display("FAIL last_n got=%0d exp=3", bus.o_z_n); end
    checks++; if (bus.o_z_l !== 1'b1) begin errors++; $display("FAIL last_l got=%b exp=1", bus.o_z_l); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1, p);
    checks++; if (bus.o_z_v !== 1'b0) begin errors++; $display("FAIL last_empty_vld got=%b exp=0", bus.o_z_v); end
    checks++; if (bus.o_z_n !== 3'd0) begin errors++; $display("FAIL last_empty_n got=%0d exp=0", bus.o_z_n); end
    drive_cycle(1'b1, 24'h161514, 1'b0, 1'b0, p);
    drive_cycle(1'b1, 24'h191817, 1'b1, 1'b0, p);
    checks++; if (bus.o_z_d !== 32'h17161514) begin errors++; $display("FAIL last_full_data got=%h exp=17161514", bus.o_z_d); end
    checks++; if (bus.o_z_n !== 3'd4 || bus.o_z_l !== 1'b0) begin errors++; $display("FAIL last_full_nl got=%0d/%b exp=4/0", bus.o_z_n, bus.o_z_l); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1, p);
    checks++; if (bus.o_z_v !== 1'b1) begin errors++; $display("FAIL last_tail_vld got=%b exp=1", bus.o_z_v); end
    checks++; if (bus.o_z_d !== 32'h00001918) begin errors++; $display("FAIL last_tail_data got=%h exp=00001918", bus.o_z_d); end
    checks++; if (bus.o_z_n !== 3'd2 || bus.o_z_l !== 1'b1) begin errors++; $display("FAIL last_tail_nl got=%0d/%b exp=2/1", bus.o_z_n, bus.o_z_l); end
  endtask
`endif

  initial begin
    bus.i_a_v = 1'b0;
    bus.i_a_d = '0;
    bus.i_z_r = 1'b0;
`ifdef CORY_PACK_LAST_EN
    bus.i_a_l = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_reset_midstream();
`ifdef CORY_PACK_LAST_EN
    test_last();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
